mem_access_ctrl: RTL

//   MEM-stage sequencer placed directly upstream of the data RAM wrapper.

---
 rtl/mem_access_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer in front of the data RAM wrapper.
// Optional alignment check: define MEM_ACCESS_MISALIGN_CHECK_EN.
module mem_access_ctrl #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        ram_wr_en,
    output logic [31:0] ram_addr,
    output logic [2:0]  ram_rw_type,
    output logic [31:0] ram_dat_i,
    input  logic [31:0] ram_dat_o,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_is_load,
    output logic        resp_err
);

    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        IDLE, RD_WAIT, LOAD, WRITE, RESP, ERR_RESP
    } state_t;

    state_t        state;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    type_q;
    logic [4:0]    rd_q;
    logic          we_q;
    logic [CW-1:0] cnt;
    logic          type_bad;
    logic          misalign;

    always_comb begin
        type_bad = (req_type == 3'b011) || (req_type == 3'b110) ||
                   (req_type == 3'b111);
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
        misalign = ((req_type[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_type == 3'b010) && (req_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
    end

    assign req_ready   = (state == IDLE);
    assign ram_wr_en   = (state == WRITE);
    assign ram_addr    = (state == IDLE) ? 32'd0 : addr_q;
    assign ram_rw_type = (state == IDLE) ? 3'd0 : type_q;
    assign ram_dat_i   = (state == IDLE) ? 32'd0 : wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            type_q       <= '0;
            rd_q         <= '0;
            we_q         <= 1'b0;
            cnt          <= '0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_rd      <= '0;
            resp_is_load <= 1'b0;
            resp_err     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        type_q  <= req_type;
                        rd_q    <= req_rd;
                        we_q    <= req_we;
                        cnt     <= CW'(RD_LAT);
                        if (type_bad || misalign) begin
                            state        <= ERR_RESP;
                            resp_valid   <= 1'b1;
                            resp_err     <= 1'b1;
                            resp_data    <= '0;
                            resp_rd      <= req_rd;
                            resp_is_load <= !req_we;
                        end else if (req_we && req_type == 3'b010) begin
                            state <= WRITE;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= we_q ? WRITE : LOAD;
                end
                LOAD: begin
                    state        <= RESP;
                    resp_valid   <= 1'b1;
                    resp_data    <= ram_dat_o;
                    resp_rd      <= rd_q;
                    resp_is_load <= 1'b1;
                end
                WRITE: begin
                    state        <= RESP;
                    resp_valid   <= 1'b1;
                    resp_data    <= '0;
                    resp_rd      <= rd_q;
                    resp_is_load <= 1'b0;
                end
                RESP, ERR_RESP: begin
                    // Response regs hold until WB takes them.
                    if (resp_ready) begin
                        state        <= IDLE;
                        resp_valid   <= 1'b0;
                        resp_err     <= 1'b0;
                        resp_data    <= '0;
                        resp_rd      <= '0;
                        resp_is_load <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
